// File: rtl/switch_port_pkg.sv
// Shared types for the switch output-port receive path: framing FSM states and header size.
package switch_port_pkg;

    typedef enum logic [2:0] {
        W_HDR,
        W_LEN,
        W_PAY,
        D_LEN,
        D_PAY
    } wr_state_e;

    typedef enum logic [1:0] {
        R_HDR,
        R_LEN,
        R_PAY
    } rd_state_e;

    localparam int HDR_BYTES = 2;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with wrap-bit binary pointers and an occupancy count.
// Latency: rdata shows the head word combinationally; a push is visible the next cycle.
// Backpressure: push while full and pop while empty are ignored; the caller watches full/empty.
module sync_fifo #(
    parameter int W_WIDTH = 8,
    parameter int DEPTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W_WIDTH-1:0]     wdata,
    input  logic                   pop,
    output logic [W_WIDTH-1:0]     rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W_WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               push_ok, pop_ok;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + ONE;
        if (push_ok && !pop_ok)      count_d = count_q + ONE;
        else if (pop_ok && !push_ok) count_d = count_q - ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/switch_port_rx.sv
// Switch port receive buffer with packet framing; SWITCH_PORT_RX_ADDR_CHECK_EN drops packets whose header != PORT_ADDR.
// Latency: data_out/data_vld one cycle after an accepted rd_en; pkt_rdy one cycle after a packet's last byte is written.
// Backpressure: port_busy when free slots <= BUSY_MARGIN; writes while full are dropped and set sticky ovf_err.
module switch_port_rx #(
    parameter int W_WIDTH     = 8,
    parameter int DEPTH       = 16,
    parameter int BUSY_MARGIN = 2
`ifdef SWITCH_PORT_RX_ADDR_CHECK_EN
    ,
    parameter int PORT_ADDR   = 0
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [W_WIDTH-1:0] data_in,
    output logic               port_busy,
    input  logic               rd_en,
    output logic [W_WIDTH-1:0] data_out,
    output logic               data_vld,
    output logic               pkt_rdy,
    output logic               ovf_err,
    output logic               addr_err
);
    import switch_port_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]        BUSY_TH = (AW+1)'(DEPTH - BUSY_MARGIN);
    localparam logic [AW:0]        CNT_ONE = (AW+1)'(1);
    localparam logic [W_WIDTH-1:0] LEN_ONE = W_WIDTH'(1);

    wr_state_e          wr_st_q, wr_st_d;
    rd_state_e          rd_st_q, rd_st_d;
    logic [W_WIDTH-1:0] len_cnt_q, len_cnt_d;
    logic [W_WIDTH-1:0] rlen_q, rlen_d;
    logic [W_WIDTH-1:0] data_out_q, data_out_d;
    logic               data_vld_q, data_vld_d;
    logic               ovf_err_q, ovf_err_d;
    logic [AW:0]        pkt_cnt_q, pkt_cnt_d;
    logic [AW:0]        count;
    logic [W_WIDTH-1:0] rdata;
    logic               full, empty, hdr_ok, store, pkt_done, pop, last_pop;

    sync_fifo #(
        .W_WIDTH (W_WIDTH),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (store),
        .wdata (data_in),
        .pop   (pop),
        .rdata (rdata),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign pop       = rd_en && !empty;
    assign port_busy = (count >= BUSY_TH);
    assign pkt_rdy   = (pkt_cnt_q != '0);
    assign data_out  = data_out_q;
    assign data_vld  = data_vld_q;
    assign ovf_err   = ovf_err_q;

    // Write framing: the FSM advances on every strobe, stored or not, so framing survives overflow.
    always_comb begin
        wr_st_d   = wr_st_q;
        len_cnt_d = len_cnt_q;
        if (wr_en) begin
            case (wr_st_q)
                W_HDR: wr_st_d = hdr_ok ? W_LEN : D_LEN;
                W_LEN, D_LEN: begin
                    len_cnt_d = data_in;
                    if (data_in == '0)        wr_st_d = W_HDR;
                    else if (wr_st_q == W_LEN) wr_st_d = W_PAY;
                    else                       wr_st_d = D_PAY;
                end
                W_PAY, D_PAY: begin
                    len_cnt_d = len_cnt_q - LEN_ONE;
                    if (len_cnt_q == LEN_ONE) wr_st_d = W_HDR;
                end
                default: wr_st_d = W_HDR;
            endcase
        end
    end

    always_comb begin
        store    = 1'b0;
        pkt_done = 1'b0;
        if (wr_en) begin
            case (wr_st_q)
                W_HDR: store = hdr_ok;
                W_LEN: begin
                    store    = 1'b1;
                    pkt_done = (data_in == '0);
                end
                W_PAY: begin
                    store    = 1'b1;
                    pkt_done = (len_cnt_q == LEN_ONE);
                end
                default: store = 1'b0;
            endcase
        end
    end

    always_comb begin
        rd_st_d = rd_st_q;
        rlen_d  = rlen_q;
        if (pop) begin
            case (rd_st_q)
                R_HDR: rd_st_d = R_LEN;
                R_LEN: begin
                    rlen_d  = rdata;
                    rd_st_d = (rdata == '0) ? R_HDR : R_PAY;
                end
                R_PAY: begin
                    rlen_d = rlen_q - LEN_ONE;
                    if (rlen_q == LEN_ONE) rd_st_d = R_HDR;
                end
                default: rd_st_d = R_HDR;
            endcase
        end
    end

    always_comb begin
        last_pop = pop && (((rd_st_q == R_LEN) && (rdata == '0)) ||
                           ((rd_st_q == R_PAY) && (rlen_q == LEN_ONE)));
        pkt_cnt_d = pkt_cnt_q;
        if (pkt_done && !last_pop)      pkt_cnt_d = pkt_cnt_q + CNT_ONE;
        else if (last_pop && !pkt_done) pkt_cnt_d = pkt_cnt_q - CNT_ONE;
        data_out_d = pop ? rdata : data_out_q;
        data_vld_d = pop;
        ovf_err_d  = ovf_err_q | (store && full);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_st_q    <= W_HDR;
            rd_st_q    <= R_HDR;
            len_cnt_q  <= '0;
            rlen_q     <= '0;
            pkt_cnt_q  <= '0;
            data_out_q <= '0;
            data_vld_q <= 1'b0;
            ovf_err_q  <= 1'b0;
        end else begin
            wr_st_q    <= wr_st_d;
            rd_st_q    <= rd_st_d;
            len_cnt_q  <= len_cnt_d;
            rlen_q     <= rlen_d;
            pkt_cnt_q  <= pkt_cnt_d;
            data_out_q <= data_out_d;
            data_vld_q <= data_vld_d;
            ovf_err_q  <= ovf_err_d;
        end
    end

`ifdef SWITCH_PORT_RX_ADDR_CHECK_EN
    logic addr_err_q, addr_err_d;

    assign hdr_ok     = (data_in == W_WIDTH'(PORT_ADDR));
    assign addr_err_d = addr_err_q | (wr_en && (wr_st_q == W_HDR) && !hdr_ok);
    assign addr_err   = addr_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) addr_err_q <= 1'b0;
        else        addr_err_q <= addr_err_d;
    end
`else
    assign hdr_ok   = 1'b1;
    assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_switch_port_rx.sv
// Randomized scoreboard bench for switch_port_rx against a packet-level queue model.
module tb_switch_port_rx;
    import switch_port_pkg::*;

    localparam int DEPTH  = 16;
    localparam int MARGIN = 2;
`ifdef SWITCH_PORT_RX_ADDR_CHECK_EN
    localparam logic [7:0] PA = 8'h03;
`endif

    logic       clk = 1'b0;
    logic       rst_n, wr_en, rd_en;
    logic [7:0] data_in, data_out;
    logic       port_busy, data_vld, pkt_rdy, ovf_err, addr_err;

    int checks = 0;
    int errors = 0;

    // Model: bytes held in the buffer, expected reads, sizes of packets not yet fully read.
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    int         rd_sizes[$];
    int         rd_pos, m_pkts;
    logic       m_ovf, m_aerr, exp_vld, exp_busy, mon_en;
    logic [7:0] m_last;

    switch_port_rx #(
        .W_WIDTH     (8),
        .DEPTH       (DEPTH),
        .BUSY_MARGIN (MARGIN)
`ifdef SWITCH_PORT_RX_ADDR_CHECK_EN
        ,
        .PORT_ADDR   (3)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .data_in   (data_in),
        .port_busy (port_busy),
        .rd_en     (rd_en),
        .data_out  (data_out),
        .data_vld  (data_vld),
        .pkt_rdy   (pkt_rdy),
        .ovf_err   (ovf_err),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        mq.delete();
        exp_q.delete();
        rd_sizes.delete();
        rd_pos   = 0;
        m_pkts   = 0;
        m_ovf    = 1'b0;
        m_aerr   = 1'b0;
        exp_vld  = 1'b0;
        exp_busy = 1'b0;
        m_last   = 8'h00;
    endtask

    // One clock cycle of stimulus; called just after a rising edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input bit keep, input bit last);
        bit         do_pop  = 1'b0;
        bit         do_push = 1'b0;
        bit         dec     = 1'b0;
        logic [7:0] popped;
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        if (r && mq.size() > 0) begin
            do_pop = 1'b1;
            exp_q.push_back(mq[0]);
        end
        if (w && keep && mq.size() < DEPTH) do_push = 1'b1;
        @(posedge clk);
        #1;
        if (do_pop) begin
            popped = mq.pop_front();
            m_last = popped;
            rd_pos++;
            if (rd_sizes.size() > 0 && rd_pos == rd_sizes[0]) begin
                rd_sizes.delete(0);
                rd_pos = 0;
                dec    = 1'b1;
            end
        end
        if (do_push) mq.push_back(d);
        if (w && keep && !do_push) m_ovf = 1'b1;
        if (last && keep) m_pkts++;
        if (dec) m_pkts--;
        exp_vld  = do_pop;
        exp_busy = ((DEPTH - mq.size()) <= MARGIN);
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        data_in  = 8'h00;
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] len, input int rd_pct);
        bit         keep;
        logic [7:0] b;
        keep = 1'b1;
`ifdef SWITCH_PORT_RX_ADDR_CHECK_EN
        keep = (hdr == PA);
`endif
        if (keep) rd_sizes.push_back(int'(len) + HDR_BYTES);
        for (int i = 0; i < int'(len) + HDR_BYTES; i++) begin
            if (i == 0)      b = hdr;
            else if (i == 1) b = len;
            else             b = 8'($urandom);
            while (keep && mq.size() >= DEPTH) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
            step(1'b1, b, ($urandom_range(99) < rd_pct), keep, (i == int'(len) + 1));
            if (i == 0 && !keep) m_aerr = 1'b1;
        end
    endtask

    task automatic drain();
        while (mq.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_data_out", data_out, 0);
        chk("rst_data_vld", data_vld, 0);
        chk("rst_pkt_rdy", pkt_rdy, 0);
        chk("rst_port_busy", port_busy, 0);
        chk("rst_ovf_err", ovf_err, 0);
        chk("rst_addr_err", addr_err, 0);
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            chk("data_vld", data_vld, exp_vld);
            if (data_vld) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL data_out: got 0x%0h with no expected word at %0t", data_out, $time);
                end else begin
                    chk("data_out", data_out, exp_q.pop_front());
                end
            end else begin
                chk("data_hold", data_out, m_last);
            end
            chk("pkt_rdy", pkt_rdy, m_pkts != 0);
            chk("port_busy", port_busy, exp_busy);
            chk("ovf_err", ovf_err, m_ovf);
            chk("addr_err", addr_err, m_aerr);
        end
    end

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = 8'h00;
        mon_en  = 1'b0;
        clear_model();
        #3;
        chk("init_data_out", data_out, 0);
        chk("init_data_vld", data_vld, 0);
        chk("init_pkt_rdy", pkt_rdy, 0);
        chk("init_port_busy", port_busy, 0);
        chk("init_ovf_err", ovf_err, 0);
        chk("init_addr_err", addr_err, 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Basic 2-byte-payload packet, then drained.
        send_pkt(8'h03, 8'h02, 0);
        chk("pkt_rdy_after_last", pkt_rdy, m_pkts != 0);
        drain();

        // Zero-length packet.
        send_pkt(8'h05, 8'h00, 0);
        chk("zero_len_rdy", pkt_rdy, m_pkts != 0);
        drain();

        // Fill to full: 16-byte packet, busy threshold at the 14th write, then overflow.
        rd_sizes.push_back(16);
        step(1'b1, 8'h03, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'd14, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b0, 1'b1, (i == 13));
            if (i == 10) chk("busy_after_13th", port_busy, 0);
            if (i == 11) chk("busy_after_14th", port_busy, 1);
        end
        step(1'b1, 8'h03, 1'b0, 1'b1, 1'b0);
        chk("ovf_after_17th", ovf_err, 1);
        step(1'b1, 8'h05, 1'b1, 1'b1, 1'b0);
        chk("ovf_after_rdwr_full", ovf_err, 1);
        drain();

        // Reset mid-payload while a read word is being presented.
        pulse_reset();
        send_pkt(8'h03, 8'h01, 0);
        rd_sizes.push_back(6);
        step(1'b1, 8'h03, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h04, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
        pulse_reset();
        send_pkt(8'h03, 8'h01, 0);
        chk("post_reset_framing", pkt_rdy, 1);
        drain();

`ifdef SWITCH_PORT_RX_ADDR_CHECK_EN
        send_pkt(8'h07, 8'h01, 0);
        send_pkt(8'h03, 8'h00, 0);
        chk("addr_err_set", addr_err, 1);
        chk("addr_pkt_rdy", pkt_rdy, 1);
        drain();
`endif

        // Randomized packets with interleaved reads and idle gaps.
        for (int p = 0; p < 40; p++) begin
            logic [7:0] hdr;
            hdr = 8'($urandom);
`ifdef SWITCH_PORT_RX_ADDR_CHECK_EN
            if ($urandom_range(1) == 0) hdr = PA;
`endif
            send_pkt(hdr, 8'($urandom_range(6)), 50);
            if ($urandom_range(3) == 0) step(1'b0, 8'h00, 1'($urandom_range(1)), 1'b1, 1'b0);
        end
        drain();
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("pkt_cnt_zero", pkt_rdy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_port_rx.md
Name: switch_port_rx

Overview:
- Receive end of a switch output port. Consumes the byte stream the switch FSM writes (wr_en/data_in) and buffers it in a FIFO.
- Drives port_busy back to the switch FSM as flow control.
- Tracks packet framing (header, length, payload) so the downstream consumer can drain whole packets through a registered read handshake.

Parameters:
- W_WIDTH, 8, data/address width; also the width of the length byte.
- DEPTH, 16, FIFO depth in words; power of 2, at least 4.
- BUSY_MARGIN, 2, port_busy asserts when the number of free slots is BUSY_MARGIN or fewer.
- PORT_ADDR, 0, this port's address; used only by the optional feature.

Ports:
- clk  in  1  clock; all logic runs on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe from the switch FSM; one byte per cycle.
- data_in  in  W_WIDTH  write data.
- port_busy  out  1  backpressure to the switch FSM.
- rd_en  in  1  read request from the consumer.
- data_out  out  W_WIDTH  read data, registered.
- data_vld  out  1  data_out is valid this cycle.
- pkt_rdy  out  1  at least one complete packet is buffered.
- ovf_err  out  1  sticky flag: a write arrived while the FIFO was full.
- addr_err  out  1  sticky flag: a packet was dropped for address mismatch (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (async, rst_n=0): pointers, count, pkt_cnt, both FSMs, data_out, data_vld, ovf_err and addr_err all clear to 0.
  - Reset mid-packet discards all buffered data; no partial packet survives.
- FIFO:
  - Binary pointers of log2(DEPTH)+1 bits, extra bit for wrap.
  - full = (count == DEPTH); empty = (count == 0).
  - count updates +1 on write only, -1 on read only, unchanged on simultaneous read and write.
- port_busy = (DEPTH - count <= BUSY_MARGIN); it is combinational from the registered count.
- Write while full: byte dropped, ovf_err set to 1 until reset, write FSM still advances so framing stays aligned.
  - full is evaluated on the registered state. A write in the same cycle as a read while full is dropped.
- Write FSM, advancing on each wr_en:
  - W_HDR: store the header, then go to W_LEN.
  - W_LEN: store the byte, load len_cnt = data_in. If data_in == 0 the packet is complete and the FSM returns to W_HDR. Otherwise go to W_PAY.
  - W_PAY: store the byte and decrement len_cnt. When len_cnt reaches 0, the packet is complete and the FSM returns to W_HDR.
  - Packet size = len + 2 bytes.
- pkt_cnt:
  - Increments the cycle after a packet-complete write.
  - Decrements when the last byte of a packet is read.
  - On simultaneous increment and decrement, it is unchanged.
  - pkt_rdy = (pkt_cnt != 0).
- Read side:
  - rd_en && !empty pops one word. Next cycle data_vld = 1 and data_out = that word; latency is 1.
  - rd_en while empty: ignored, data_vld = 0 next cycle.
  - data_out holds its last value while data_vld = 0.
- Read FSM: R_HDR -> R_LEN (loads rlen) -> R_PAY (counts down) -> R_HDR.
  - A zero-length packet ends at R_LEN.
  - The last-byte pop decrements pkt_cnt.
- Simultaneous write and read on an empty FIFO: the read is ignored and the write is accepted.

Optional Feature:
- Macro: SWITCH_PORT_RX_ADDR_CHECK_EN.
- Defined:
  - In W_HDR, if data_in != PORT_ADDR, the write FSM enters drop states D_LEN -> D_PAY and counts off the whole packet without storing any byte.
  - The dropped packet does not count toward pkt_cnt. addr_err is set sticky.
  - Overflow in drop states does not set ovf_err.
- Undefined: every header is accepted; addr_err is tied to 0.

Decomposition:
- Package switch_port_pkg:
  - write FSM state enum W_HDR/W_LEN/W_PAY/D_LEN/D_PAY;
  - read FSM state enum R_HDR/R_LEN/R_PAY;
  - HDR_BYTES = 2.
- One sub-module, sync_fifo: W_WIDTH/DEPTH storage, pointers, count, full/empty.
  - The framing FSMs, pkt_cnt and error flags stay in switch_port_rx.

Test Plan:
- Reset, then write 0x03,0x02,0xAA,0xBB -> pkt_rdy = 1 one cycle after 0xBB; 4 rd_en pops give data_vld with 03,02,AA,BB, and pkt_rdy = 0 after the BB pop.
- Zero-length packet 0x05,0x00 -> pkt_cnt = 1; two reads empty the FIFO and pkt_rdy drops.
- DEPTH = 16, BUSY_MARGIN = 2, 14 writes with no reads -> port_busy = 1 after the 14th write; the 17th write sets ovf_err and count stays 16.
- Full FIFO with rd_en and wr_en in the same cycle -> write dropped, count = 15, ovf_err = 1.
- rst_n pulsed low mid-payload -> all outputs 0 asynchronously; a new packet afterwards is framed correctly from W_HDR.
- With SWITCH_PORT_RX_ADDR_CHECK_EN and PORT_ADDR = 3, send 0x07,0x01,0x11 then 0x03,0x00 -> only 03,00 is buffered, addr_err = 1, pkt_cnt = 1.
